// File: rtl/gearbox_deserializer.sv
// gearbox_deserializer
//   Collects IN_W-bit beats into a bit accumulator and emits WORD_W-bit words.
//   WORD_W need not be a multiple of IN_W; leftover bits stay in the
//   accumulator for the next word. Supports valid/ready on both sides, a
//   one-bit bitslip for block alignment, and a synchronous flush.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_data    in   [IN_W-1:0]   input beat, MSB is the oldest bit
//   in_valid   in   beat present
//   in_ready   out  beat accepted when in_valid && in_ready (combinational)
//   bitslip    in   pulse: drop one bit from the stream
//   flush      in   synchronous clear of all buffered data
//   out_data   out  [WORD_W-1:0] assembled word, MSB is the oldest bit
//   out_valid  out  out_data holds a word
//   out_ready  in   word consumed when out_valid && out_ready
//   level      out  [LVL_W-1:0]  bits held in the accumulator
//   busy       out  level != 0 || out_valid
module gearbox_deserializer #(
  parameter int WORD_W = 130,
  parameter int IN_W   = 32,
  parameter int LVL_W  = $clog2(WORD_W + IN_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bitslip,
  input  logic              flush,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              busy
);

  localparam int CAP = WORD_W + IN_W;
  localparam logic [LVL_W-1:0] WORD_L = LVL_W'(WORD_W);
  localparam logic [LVL_W-1:0] IN_L   = LVL_W'(IN_W);
  localparam logic [LVL_W-1:0] ONE_L  = LVL_W'(1);

  // Valid bits are left-justified: the oldest bit sits at acc[CAP-1] and the
  // fill bits below it are always zero, so appends can simply be OR-ed in.
  logic [CAP-1:0]    acc, acc_n;
  logic [LVL_W-1:0]  fill, fill_n;
  logic              slip_pend, slip_pend_n;
  logic              out_valid_n;
  logic [WORD_W-1:0] out_data_n;
  logic              move;
  logic              accept;

  assign move     = (fill >= WORD_L) && (!out_valid || out_ready);
  assign in_ready = !flush && ((fill < WORD_L) || move);
  assign accept   = in_valid && in_ready;
  assign level    = fill;
  assign busy     = (fill != '0) || out_valid;

  always_comb begin
    acc_n       = acc;
    fill_n      = fill;
    slip_pend_n = slip_pend;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    if (flush) begin
      acc_n       = '0;
      fill_n      = '0;
      slip_pend_n = 1'b0;
      out_valid_n = 1'b0;
    end else begin
      if (move) begin
        out_data_n  = acc[CAP-1 -: WORD_W];
        out_valid_n = 1'b1;
        acc_n       = acc << WORD_W;
        fill_n      = fill - WORD_L;
      end else if (out_valid && out_ready) begin
        out_valid_n = 1'b0;
      end
      // After a move fill_n < IN_W, otherwise fill_n < WORD_W: the beat
      // always lands inside the CAP-bit window.
      if (accept) begin
        acc_n  = acc_n | ({in_data, {WORD_W{1'b0}}} >> fill_n);
        fill_n = fill_n + IN_L;
      end
      if (bitslip || slip_pend) begin
        if (fill_n != '0) begin
          acc_n       = acc_n << 1;
          fill_n      = fill_n - ONE_L;
          slip_pend_n = 1'b0;
        end else begin
          slip_pend_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      fill      <= '0;
      slip_pend <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      acc       <= acc_n;
      fill      <= fill_n;
      slip_pend <= slip_pend_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

endmodule

// File: tb/tb_gearbox_deserializer.sv
module tb_gearbox_deserializer;

  localparam int WW = 130;
  localparam int IW = 32;
  localparam int LW = $clog2(WW + IW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IW-1:0] in_data;
  logic          in_valid, in_ready, bitslip, flush, out_valid, out_ready, busy;
  logic [WW-1:0] out_data;
  logic [LW-1:0] level;

  gearbox_deserializer #(.WORD_W(WW), .IN_W(IW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bitslip(bitslip), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .busy(busy)
  );

  // corner: IN_W == WORD_W == 8
  logic [7:0] c8_d, c8_od;
  logic       c8_iv, c8_ir, c8_ov, c8_or, c8_busy;
  logic [4:0] c8_lv;
  gearbox_deserializer #(.WORD_W(8), .IN_W(8)) u_c8 (
    .clk(clk), .rst(rst), .in_data(c8_d), .in_valid(c8_iv), .in_ready(c8_ir),
    .bitslip(1'b0), .flush(1'b0), .out_data(c8_od), .out_valid(c8_ov),
    .out_ready(c8_or), .level(c8_lv), .busy(c8_busy)
  );

  // corner: IN_W == 1, WORD_W == 130
  logic [0:0]   c1_d;
  logic         c1_iv, c1_ir, c1_ov, c1_or, c1_busy;
  logic [129:0] c1_od;
  logic [7:0]   c1_lv;
  gearbox_deserializer #(.WORD_W(130), .IN_W(1)) u_c1 (
    .clk(clk), .rst(rst), .in_data(c1_d), .in_valid(c1_iv), .in_ready(c1_ir),
    .bitslip(1'b0), .flush(1'b0), .out_data(c1_od), .out_valid(c1_ov),
    .out_ready(c1_or), .level(c1_lv), .busy(c1_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  // reference model: bit queue of the accumulator, one output slot
  bit            mq[$];
  logic [WW-1:0] exp_q[$];
  bit            m_slot = 1'b0;
  bit            m_pend = 1'b0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock of stimulus: drive, compare DUT state to model, advance model
  task automatic step(input logic iv, input logic [IW-1:0] d, input logic bs,
                      input logic fl, input logic ordy);
    bit            mv, rdy;
    logic [WW-1:0] w;
    @(posedge clk);
    #1;
    in_valid = iv; in_data = d; bitslip = bs; flush = fl; out_ready = ordy;
    #3;
    mv  = (mq.size() >= WW) && (!m_slot || ordy);
    rdy = !fl && ((mq.size() < WW) || mv);
    chk("in_ready", 160'(in_ready), 160'(rdy));
    chk("out_valid", 160'(out_valid), 160'(m_slot));
    chk("level", 160'(level), 160'(mq.size()));
    chk("busy", 160'(busy), 160'((mq.size() != 0) || m_slot));
    if (fl) begin
      if (m_slot && !ordy) void'(exp_q.pop_back());
      mq.delete();
      m_pend = 1'b0;
      m_slot = 1'b0;
    end else begin
      if (mv) begin
        for (int i = 0; i < WW; i++) w[WW-1-i] = mq.pop_front();
        exp_q.push_back(w);
        m_slot = 1'b1;
      end else if (m_slot && ordy) begin
        m_slot = 1'b0;
      end
      if (iv && rdy)
        for (int i = IW - 1; i >= 0; i--) mq.push_back(d[i]);
      if (bs || m_pend) begin
        if (mq.size() > 0) begin
          void'(mq.pop_front());
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    in_valid = 1'b0; bitslip = 1'b0; flush = 1'b0; rst = 1'b1;
    #1;
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_level", 160'(level), 160'(0));
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("rst_busy", 160'(busy), 160'(0));
    mq.delete(); exp_q.delete(); m_slot = 1'b0; m_pend = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // monitor: a word is consumed on the edge following a negedge where
  // out_valid && out_ready hold
  initial begin
    logic [WW-1:0] w;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none at %0t", out_data, $time);
        end else begin
          w = exp_q.pop_front();
          chk("word", 160'(out_data), 160'(w));
        end
      end
    end
  end

  initial begin
    int w0;
    logic [7:0]   v8;
    logic [129:0] w1;
    in_valid = 0; in_data = '0; bitslip = 0; flush = 0; out_ready = 1;
    c8_iv = 0; c8_d = '0; c8_or = 1;
    c1_iv = 0; c1_d = '0; c1_or = 1;
    #2;
    chk("init_out_valid", 160'(out_valid), 160'(0));
    chk("init_level", 160'(level), 160'(0));
    chk("init_in_ready", 160'(in_ready), 160'(1));
    chk("init_out_data", 160'(out_data), 160'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: reset mid-stream, no stale word afterwards
    for (int i = 0; i < 7; i++) step(1'b1, IW'($urandom), 1'b0, 1'b0, 1'b1);
    reset_mid();
    idle(4);

    // T2: 65 back-to-back beats -> 16 words
    w0 = n_words;
    for (int b = 0; b < 65; b++) step(1'b1, IW'(b), 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("t2_word_count", 160'(n_words - w0), 160'(16));
    chk("t2_level", 160'(level), 160'(0));

    // T3: backpressure
    for (int i = 0; i < 12; i++) step(1'b1, IW'($urandom), 1'b0, 1'b0, 1'b0);
    chk("t3_level", 160'(level), 160'(158));
    chk("t3_in_ready", 160'(in_ready), 160'(0));
    chk("t3_out_valid", 160'(out_valid), 160'(1));
    idle(6);

    // T4: bitslip with empty accumulator, extra pulses while pending
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, IW'($urandom), 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("t4_level", 160'(level), 160'(29));

    // T5: flush after 3 beats, flushed beat not accepted
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, IW'($urandom), 1'b0, 1'b0, 1'b1);
    step(1'b1, IW'($urandom), 1'b0, 1'b1, 1'b1);
    idle(1);
    chk("t5_level", 160'(level), 160'(0));
    chk("t5_out_valid", 160'(out_valid), 160'(0));
    for (int i = 0; i < 5; i++) step(1'b1, IW'($urandom), 1'b0, 1'b0, 1'b1);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, IW'($urandom), ($urandom % 40) == 0,
           ($urandom % 150) == 0, ($urandom % 3) != 0);
    idle(10);
    chk("drain_pending_words", 160'(exp_q.size()), 160'(0));

    // T6a: IN_W == WORD_W == 8, latency 2 edges
    for (int k = 0; k < 4; k++) begin
      v8 = 8'($urandom);
      @(posedge clk);
      #1 c8_iv = 1'b1; c8_d = v8;
      @(posedge clk);
      #1 c8_iv = 1'b0;
      chk("c8_valid_early", 160'(c8_ov), 160'(0));
      chk("c8_level", 160'(c8_lv), 160'(8));
      @(posedge clk);
      #1;
      chk("c8_valid", 160'(c8_ov), 160'(1));
      chk("c8_data", 160'(c8_od), 160'(v8));
    end

    // T6b: IN_W == 1, 130 beats per word
    for (int i = 0; i < 130; i++) begin
      @(posedge clk);
      #1 c1_iv = 1'b1; c1_d = 1'($urandom); w1[129-i] = c1_d[0];
    end
    @(posedge clk);
    #1 c1_iv = 1'b0;
    chk("c1_valid_early", 160'(c1_ov), 160'(0));
    chk("c1_level", 160'(c1_lv), 160'(130));
    @(posedge clk);
    #1;
    chk("c1_valid", 160'(c1_ov), 160'(1));
    chk("c1_data", 160'(c1_od), 160'(w1));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
